// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, idle fill byte and state encoding for the SPI slave responder
package spi_pkg;
    localparam int         SPI_DATA_WIDTH  = 8;
    localparam int         SPI_SYNC_STAGES = 2;
    localparam logic [7:0] SPI_IDLE_FILL   = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;
endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - multi-flop pin synchronizer with rise/fall pulses for one asynchronous SPI pin
module spi_pin_sync
    import spi_pkg::*;
#(
    parameter int   STAGES    = SPI_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;
endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave with single-entry TX buffer and RX byte strobe
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int                    SYNC_STAGES = SPI_SYNC_STAGES,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL   = DATA_WIDTH'(SPI_IDLE_FILL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic                  active, frame_start, sample, launch, reload;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_buf_q;
    logic                  tx_full_q;
    logic [DATA_WIDTH-2:0] rx_shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;

    // A cs_n rise in the same cycle as an sclk edge suppresses that edge.
    assign active      = (state_q == ACTIVE);
    assign frame_start = (state_q == IDLE) && cs_fall;
    assign sample      = active && sclk_rise && !cs_rise;
    assign launch      = active && sclk_fall && !cs_rise;
    assign reload      = frame_start || (launch && bit_cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // Consumption looks at the buffer state before any same-cycle load.
            if (reload) begin
                if (tx_full_q) begin
                    tx_shift_q <= tx_buf_q;
                    tx_full_q  <= 1'b0;
                end else begin
                    tx_shift_q  <= IDLE_FILL;
                    tx_underrun <= 1'b1;
                end
            end else if (launch) begin
                tx_shift_q <= tx_shift_q << 1;
            end

            if (tx_load && !tx_full_q) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end

            if (frame_start || (active && cs_rise)) begin
                bit_cnt_q <= '0;
            end else if (sample) begin
                rx_shift_q <= {rx_shift_q[DATA_WIDTH-3:0], mosi_sync};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q <= '0;
                    rx_data   <= {rx_shift_q, mosi_sync};
                    rx_valid  <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign miso     = active & tx_shift_q[DATA_WIDTH-1];
    assign miso_oe  = active;
    assign tx_ready = ~tx_full_q;
    assign busy     = ~cs_level;
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb/tb_spi_slave_responder.sv - self-checking bench for spi_slave_responder
module tb_spi_slave_responder;
    localparam int         HALF = 4;
    localparam logic [7:0] FILL = 8'h00;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi, miso, miso_oe, tx_load, tx_ready;
    logic       rx_valid, tx_underrun, busy;
    logic [7:0] tx_data, rx_data;

    spi_slave_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rx_q[$];
    int         unr_cnt = 0;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_underrun) unr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        @(negedge clk);
        tx_load = 1'b0;
        repeat (HALF - 1) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        @(negedge clk);
    endtask

    // Mode-0 master; the last sclk fall and the cs_n release happen together.
    task automatic run_frame(input logic [31:0] bits, input int nbits, input int mid_bit,
                             input logic [7:0] mid_val, output logic [31:0] got);
        got = '0;
        @(negedge clk);
        cs_n = 1'b0;
        mosi = bits[nbits-1];
        half();
        for (int i = 0; i < nbits; i++) begin
            got  = {got[30:0], miso};
            sclk = 1'b1;
            if (i == mid_bit) begin
                tx_data = mid_val;
                tx_load = 1'b1;
            end
            half();
            sclk = 1'b0;
            if (i == nbits - 1) cs_n = 1'b1;
            else mosi = bits[nbits-2-i];
            half();
        end
        repeat (HALF) @(negedge clk);
    endtask

    // Reference model: a one-deep byte mailbox consumed at each byte boundary.
    logic       m_full;
    logic [7:0] m_buf, m_rx;

    task automatic model_load(input logic [7:0] v);
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = v;
        end
    endtask

    typedef struct {
        logic        pre_ld;
        logic [7:0]  pre_val;
        logic        pre2_ld;
        logic [7:0]  pre2_val;
        int          mid_bit;
        logic [7:0]  mid_val;
        logic [31:0] mosi_bits;
        int          nbits;
        logic [31:0] exp_miso;
        int          exp_rx;
        int          exp_unr;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        logic        exp_ready;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] got, bits, exp_miso;
    logic [7:0]  v, mv, b;
    int          nbits, mid, nb, nrx, exp_unr;
    logic        mid_done;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, -1, 8'h00, 32'h3C,   8,  32'hA5,   1, 0, 8'h3C, 8'h3C, 1'b1};
        vecs[1] = '{1'b1, 8'hF0, 1'b0, 8'h00, -1, 8'h00, 32'h0180, 16, 32'hF000, 2, 1, 8'h01, 8'h80, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00,  2, 8'h5A, 32'h1F,   5,  32'h00,   0, 1, 8'h00, 8'h80, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, -1, 8'h00, 32'h96,   8,  32'h5A,   1, 0, 8'h96, 8'h96, 1'b1};
        vecs[4] = '{1'b1, 8'h11, 1'b1, 8'h22, -1, 8'h00, 32'h00,   8,  32'h11,   1, 0, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, -1, 8'h00, 32'hC3,   8,  32'h00,   1, 1, 8'hC3, 8'hC3, 1'b1};
        vecs[6] = '{1'b1, 8'h77, 1'b0, 8'h00,  2, 8'h99, 32'h1234, 16, 32'h7799, 2, 0, 8'h12, 8'h34, 1'b1};

        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset miso", miso, 0);
        check("reset miso_oe", miso_oe, 0);
        check("reset tx_ready", tx_ready, 1);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset tx_underrun", tx_underrun, 0);
        check("reset busy", busy, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame after three sclk rises.
        rx_q.delete();
        cs_n = 1'b0; mosi = 1'b1;
        half();
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; half();
            sclk = 1'b0; half();
        end
        check("midframe busy", busy, 1);
        check("midframe miso_oe", miso_oe, 1);
        pulse_load(8'h6B);
        check("midframe tx_ready after load", tx_ready, 0);
        rst = 1'b0;
        #1;
        check("async reset miso_oe", miso_oe, 0);
        check("async reset miso", miso, 0);
        check("async reset tx_ready", tx_ready, 1);
        cs_n = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset frame rx_valid count", rx_q.size(), 0);

        for (int t = 0; t < 7; t++) begin
            if (vecs[t].pre_ld) begin
                pulse_load(vecs[t].pre_val);
                check($sformatf("vec%0d tx_ready after load", t), tx_ready, 0);
            end
            if (vecs[t].pre2_ld) pulse_load(vecs[t].pre2_val);
            rx_q.delete();
            unr_cnt = 0;
            run_frame(vecs[t].mosi_bits, vecs[t].nbits, vecs[t].mid_bit, vecs[t].mid_val, got);
            check($sformatf("vec%0d miso", t), got, vecs[t].exp_miso);
            check($sformatf("vec%0d rx_valid count", t), rx_q.size(), vecs[t].exp_rx);
            check($sformatf("vec%0d underrun count", t), unr_cnt, vecs[t].exp_unr);
            check($sformatf("vec%0d rx_data", t), rx_data, vecs[t].exp_last);
            check($sformatf("vec%0d tx_ready", t), tx_ready, vecs[t].exp_ready);
            if (rx_q.size() > 0)
                check($sformatf("vec%0d first rx byte", t), rx_q[0], vecs[t].exp_first);
        end

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        m_full = 1'b0; m_buf = 8'h00; m_rx = 8'h00;

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = 8'($urandom);
                check($sformatf("rnd%0d tx_ready before load", it), tx_ready, {31'd0, ~m_full});
                pulse_load(v);
                model_load(v);
            end
            if ($urandom_range(0, 3) == 0) begin
                v = 8'($urandom);
                pulse_load(v);
                model_load(v);
            end
            nbits = $urandom_range(1, 24);
            bits  = $urandom & ((32'h1 << nbits) - 1);
            mid   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nbits - 1)) : -1;
            mv    = 8'($urandom);
            rx_q.delete();
            unr_cnt = 0;
            run_frame(bits, nbits, mid, mv, got);

            nb = (nbits + 7) / 8;
            exp_miso = '0;
            exp_unr  = 0;
            mid_done = (mid < 0);
            for (int k = 0; k < nb; k++) begin
                if (!mid_done && mid < 8 * k) begin
                    model_load(mv);
                    mid_done = 1'b1;
                end
                if (m_full) begin
                    b = m_buf;
                    m_full = 1'b0;
                end else begin
                    b = FILL;
                    exp_unr++;
                end
                exp_miso = (exp_miso << 8) | {24'd0, b};
            end
            if (!mid_done) model_load(mv);
            exp_miso = exp_miso >> (8 * nb - nbits);

            nrx = nbits / 8;
            check($sformatf("rnd%0d miso", it), got, exp_miso);
            check($sformatf("rnd%0d underrun count", it), unr_cnt, exp_unr);
            check($sformatf("rnd%0d rx_valid count", it), rx_q.size(), nrx);
            for (int j = 0; j < nrx && j < rx_q.size(); j++)
                check($sformatf("rnd%0d rx byte %0d", it, j), rx_q[j], 8'(bits >> (nbits - 8 * (j + 1))));
            if (nrx > 0) m_rx = 8'(bits >> (nbits - 8 * nrx));
            check($sformatf("rnd%0d rx_data", it), rx_data, m_rx);
            check($sformatf("rnd%0d tx_ready", it), tx_ready, {31'd0, ~m_full});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
